axi_res_tbl_ctrl: RTL and testbench

// Front-end sequencer for the AXI reservation table (LR/SC support in the atomics adapter).

---
 rtl/axi_res_tbl_ctrl.sv | 238 +++++++++++++++++++++++
 tb/tb_axi_res_tbl_ctrl.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_res_tbl_ctrl.sv
// ---------------------------------------------------------------------------
// axi_res_tbl_ctrl
// Front-end sequencer for the AXI reservation table used for LR/SC atomics.
// Three valid/ready request streams (plain-write clear, LR set, SC check) are
// arbitrated round-robin onto the table's clr/set/check ports, one request
// per cycle at most. A successful SC check is followed by an exclusive clear
// of the SC address before the SC response is issued, so no other request
// can slip between the check and the clear.
//
// Ports
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   wr_valid_i/wr_ready_o/wr_addr_i    plain-write clear requests
//   lr_valid_i/lr_ready_o/lr_addr_i/lr_id_i        LR set requests
//   sc_valid_i/sc_ready_o/sc_addr_i/sc_id_i        SC check requests
//   sc_rsp_valid_o/sc_rsp_ready_i/sc_rsp_ok_o/sc_rsp_id_o   SC result
//   tbl_clr_*   table clear port (req/addr out, gnt in)
//   tbl_set_*   table set port (req/addr/id out, gnt in)
//   tbl_check_* table check port (req/addr/id out, res/gnt in)
// ---------------------------------------------------------------------------
module axi_res_tbl_ctrl #(
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] wr_addr_i,
  input  logic                      lr_valid_i,
  output logic                      lr_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] lr_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   lr_id_i,
  input  logic                      sc_valid_i,
  output logic                      sc_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0] sc_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]   sc_id_i,
  output logic                      sc_rsp_valid_o,
  input  logic                      sc_rsp_ready_i,
  output logic                      sc_rsp_ok_o,
  output logic [AXI_ID_WIDTH-1:0]   sc_rsp_id_o,
  output logic                      tbl_clr_req_o,
  output logic [AXI_ADDR_WIDTH-1:0] tbl_clr_addr_o,
  input  logic                      tbl_clr_gnt_i,
  output logic                      tbl_set_req_o,
  output logic [AXI_ADDR_WIDTH-1:0] tbl_set_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   tbl_set_id_o,
  input  logic                      tbl_set_gnt_i,
  output logic                      tbl_check_req_o,
  output logic [AXI_ADDR_WIDTH-1:0] tbl_check_addr_o,
  output logic [AXI_ID_WIDTH-1:0]   tbl_check_id_o,
  input  logic                      tbl_check_res_i,
  input  logic                      tbl_check_gnt_i
);

  localparam logic [1:0] IDX_WR = 2'd0;
  localparam logic [1:0] IDX_LR = 2'd1;
  localparam logic [1:0] IDX_SC = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SC_CLR  = 2'd1,
    S_SC_RESP = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [1:0]                r_rr_ptr;
  logic                      r_lock;
  logic [1:0]                r_lock_idx;
  logic [AXI_ADDR_WIDTH-1:0] r_sc_addr;
  logic [AXI_ID_WIDTH-1:0]   r_sc_id;
  logic                      r_sc_ok;

  logic [3:0] w_elig;
  logic [1:0] w_cand0;
  logic [1:0] w_cand1;
  logic [1:0] w_cand2;
  logic [1:0] w_win;
  logic       w_win_vld;
  logic       w_win_gnt;
  logic       w_gnt;
  logic       w_sc_accept;

  function automatic logic [1:0] f_inc_mod3(input logic [1:0] a);
    return (a == 2'd2) ? 2'd0 : a + 2'd1;
  endfunction

  // SC may only start from IDLE; during the exclusive clear nobody else runs.
  // Bit 3 pads the vector so any 2-bit index is in range.
  assign w_elig[IDX_WR] = wr_valid_i && (r_state != S_SC_CLR);
  assign w_elig[IDX_LR] = lr_valid_i && (r_state != S_SC_CLR);
  assign w_elig[IDX_SC] = sc_valid_i && (r_state == S_IDLE);
  assign w_elig[3]      = 1'b0;

  assign w_cand0 = r_rr_ptr;
  assign w_cand1 = f_inc_mod3(w_cand0);
  assign w_cand2 = f_inc_mod3(w_cand1);

  // Round-robin search from rr_ptr; a stalled winner stays locked in so
  // its request never changes under the table while gnt is low.
  always_comb begin
    w_win     = r_rr_ptr;
    w_win_vld = 1'b0;
    if (r_lock) begin
      w_win     = r_lock_idx;
      w_win_vld = w_elig[r_lock_idx];
    end else if (w_elig[w_cand0]) begin
      w_win     = w_cand0;
      w_win_vld = 1'b1;
    end else if (w_elig[w_cand1]) begin
      w_win     = w_cand1;
      w_win_vld = 1'b1;
    end else if (w_elig[w_cand2]) begin
      w_win     = w_cand2;
      w_win_vld = 1'b1;
    end
  end

  always_comb begin
    case (w_win)
      IDX_WR:  w_win_gnt = tbl_clr_gnt_i;
      IDX_LR:  w_win_gnt = tbl_set_gnt_i;
      IDX_SC:  w_win_gnt = tbl_check_gnt_i;
      default: w_win_gnt = 1'b0;
    endcase
  end

  assign w_gnt       = w_win_vld && w_win_gnt;
  assign w_sc_accept = w_gnt && (w_win == IDX_SC);

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_sc_accept) begin
          w_state_next = tbl_check_res_i ? S_SC_CLR : S_SC_RESP;
        end
      end
      S_SC_CLR: begin
        if (tbl_clr_gnt_i) begin
          w_state_next = S_SC_RESP;
        end
      end
      S_SC_RESP: begin
        if (sc_rsp_ready_i) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // FSM: outputs. Everything is held low while reset is asserted, even
  // though the valids may already be high.
  always_comb begin
    wr_ready_o       = 1'b0;
    lr_ready_o       = 1'b0;
    sc_ready_o       = 1'b0;
    tbl_clr_req_o    = 1'b0;
    tbl_clr_addr_o   = '0;
    tbl_set_req_o    = 1'b0;
    tbl_set_addr_o   = '0;
    tbl_set_id_o     = '0;
    tbl_check_req_o  = 1'b0;
    tbl_check_addr_o = '0;
    tbl_check_id_o   = '0;
    sc_rsp_valid_o   = 1'b0;
    sc_rsp_ok_o      = 1'b0;
    if (rst_ni) begin
      if (r_state == S_SC_CLR) begin
        tbl_clr_req_o  = 1'b1;
        tbl_clr_addr_o = r_sc_addr;
      end else if (w_win_vld) begin
        case (w_win)
          IDX_WR: begin
            tbl_clr_req_o  = 1'b1;
            tbl_clr_addr_o = wr_addr_i;
            wr_ready_o     = tbl_clr_gnt_i;
          end
          IDX_LR: begin
            tbl_set_req_o  = 1'b1;
            tbl_set_addr_o = lr_addr_i;
            tbl_set_id_o   = lr_id_i;
            lr_ready_o     = tbl_set_gnt_i;
          end
          IDX_SC: begin
            tbl_check_req_o  = 1'b1;
            tbl_check_addr_o = sc_addr_i;
            tbl_check_id_o   = sc_id_i;
            sc_ready_o       = tbl_check_gnt_i;
          end
          default: ;
        endcase
      end
      sc_rsp_valid_o = (r_state == S_SC_RESP);
      sc_rsp_ok_o    = (r_state == S_SC_RESP) && r_sc_ok;
    end
  end

  assign sc_rsp_id_o = r_sc_id;

  // Arbitration and SC context. The exclusive clear never touches rr_ptr
  // because no stream wins in SC_CLR.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr   <= 2'd0;
      r_lock     <= 1'b0;
      r_lock_idx <= 2'd0;
      r_sc_addr  <= '0;
      r_sc_id    <= '0;
      r_sc_ok    <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_rr_ptr <= f_inc_mod3(w_win);
        r_lock   <= 1'b0;
      end else if (w_win_vld) begin
        r_lock     <= 1'b1;
        r_lock_idx <= w_win;
      end
      if (w_sc_accept) begin
        r_sc_addr <= sc_addr_i;
        r_sc_id   <= sc_id_i;
        r_sc_ok   <= tbl_check_res_i;
      end
    end
  end

endmodule

// File: tb/tb_axi_res_tbl_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi_res_tbl_ctrl
// Self-checking bench for axi_res_tbl_ctrl. A behavioural reservation table
// answers the controller's clr/set/check ports. Expected table grants and SC
// responses are queued when stimulus is driven and compared in order when
// the DUT produces them.
// ---------------------------------------------------------------------------
module tb_axi_res_tbl_ctrl;

  localparam int AW = 64;
  localparam int IW = 4;

  localparam logic [1:0] K_WR  = 2'd0;
  localparam logic [1:0] K_LR  = 2'd1;
  localparam logic [1:0] K_SC  = 2'd2;
  localparam logic [1:0] K_CLR = 2'd3;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          wr_valid_i;
  logic          wr_ready_o;
  logic [AW-1:0] wr_addr_i;
  logic          lr_valid_i;
  logic          lr_ready_o;
  logic [AW-1:0] lr_addr_i;
  logic [IW-1:0] lr_id_i;
  logic          sc_valid_i;
  logic          sc_ready_o;
  logic [AW-1:0] sc_addr_i;
  logic [IW-1:0] sc_id_i;
  logic          sc_rsp_valid_o;
  logic          sc_rsp_ready_i;
  logic          sc_rsp_ok_o;
  logic [IW-1:0] sc_rsp_id_o;
  logic          tbl_clr_req_o;
  logic [AW-1:0] tbl_clr_addr_o;
  logic          tbl_clr_gnt_i;
  logic          tbl_set_req_o;
  logic [AW-1:0] tbl_set_addr_o;
  logic [IW-1:0] tbl_set_id_o;
  logic          tbl_set_gnt_i;
  logic          tbl_check_req_o;
  logic [AW-1:0] tbl_check_addr_o;
  logic [IW-1:0] tbl_check_id_o;
  logic          tbl_check_res_i;
  logic          tbl_check_gnt_i;

  always #5 clk_i = ~clk_i;

  axi_res_tbl_ctrl #(.AXI_ADDR_WIDTH(AW), .AXI_ID_WIDTH(IW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .wr_valid_i       (wr_valid_i),
    .wr_ready_o       (wr_ready_o),
    .wr_addr_i        (wr_addr_i),
    .lr_valid_i       (lr_valid_i),
    .lr_ready_o       (lr_ready_o),
    .lr_addr_i        (lr_addr_i),
    .lr_id_i          (lr_id_i),
    .sc_valid_i       (sc_valid_i),
    .sc_ready_o       (sc_ready_o),
    .sc_addr_i        (sc_addr_i),
    .sc_id_i          (sc_id_i),
    .sc_rsp_valid_o   (sc_rsp_valid_o),
    .sc_rsp_ready_i   (sc_rsp_ready_i),
    .sc_rsp_ok_o      (sc_rsp_ok_o),
    .sc_rsp_id_o      (sc_rsp_id_o),
    .tbl_clr_req_o    (tbl_clr_req_o),
    .tbl_clr_addr_o   (tbl_clr_addr_o),
    .tbl_clr_gnt_i    (tbl_clr_gnt_i),
    .tbl_set_req_o    (tbl_set_req_o),
    .tbl_set_addr_o   (tbl_set_addr_o),
    .tbl_set_id_o     (tbl_set_id_o),
    .tbl_set_gnt_i    (tbl_set_gnt_i),
    .tbl_check_req_o  (tbl_check_req_o),
    .tbl_check_addr_o (tbl_check_addr_o),
    .tbl_check_id_o   (tbl_check_id_o),
    .tbl_check_res_i  (tbl_check_res_i),
    .tbl_check_gnt_i  (tbl_check_gnt_i)
  );

  // Behavioural reservation table: one {valid, addr} entry per ID.
  logic          tm_vld  [16];
  logic [AW-1:0] tm_addr [16];

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) begin
        tm_vld[i]  <= 1'b0;
        tm_addr[i] <= '0;
      end
    end else begin
      if (tbl_clr_req_o && tbl_clr_gnt_i) begin
        for (int i = 0; i < 16; i++) begin
          if (tm_addr[i] == tbl_clr_addr_o) tm_vld[i] <= 1'b0;
        end
      end
      if (tbl_set_req_o && tbl_set_gnt_i) begin
        tm_vld[tbl_set_id_o]  <= 1'b1;
        tm_addr[tbl_set_id_o] <= tbl_set_addr_o;
      end
    end
  end

  assign tbl_check_res_i = tm_vld[tbl_check_id_o] && (tm_addr[tbl_check_id_o] == tbl_check_addr_o);

  // Scoreboard
  typedef struct packed {
    logic [1:0]    kind;
    logic [AW-1:0] addr;
    logic [IW-1:0] id;
  } gexp_t;

  typedef struct packed {
    logic          ok;
    logic [IW-1:0] id;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("[%0t] FAIL %s: got 0x%0h want 0x%0h", $time, tag, obs, exp);
    end
  endtask

  task automatic push_g(input logic [1:0] kind, input logic [AW-1:0] addr, input logic [IW-1:0] id);
    gexp_t e;
    e.kind = kind;
    e.addr = addr;
    e.id   = id;
    gq.push_back(e);
  endtask

  task automatic push_r(input logic ok, input logic [IW-1:0] id);
    rexp_t e;
    e.ok = ok;
    e.id = id;
    rq.push_back(e);
  endtask

  task automatic log_grant(input logic [1:0] kind, input logic [AW-1:0] addr, input logic [IW-1:0] id);
    gexp_t e;
    $display("[%0t] grant kind=%0d addr=0x%0h id=%0d", $time, kind, addr, id);
    if (gq.size() == 0) begin
      check_eq("grant_unexpected", {62'd0, kind}, 64'hDEAD);
    end else begin
      e = gq.pop_front();
      check_eq("grant_kind", {62'd0, kind}, {62'd0, e.kind});
      check_eq("grant_addr", addr, e.addr);
      check_eq("grant_id", {60'd0, id}, {60'd0, e.id});
    end
  endtask

  // Output monitor, sampled mid-cycle.
  always @(negedge clk_i) begin
    rexp_t r;
    if (rst_ni) begin
      check_eq("one_tbl_req", {63'd0, (32'(tbl_clr_req_o) + 32'(tbl_set_req_o) + 32'(tbl_check_req_o)) <= 1}, 1);
      if (wr_valid_i && wr_ready_o) log_grant(K_WR, tbl_clr_addr_o, '0);
      if (lr_valid_i && lr_ready_o) log_grant(K_LR, tbl_set_addr_o, tbl_set_id_o);
      if (sc_valid_i && sc_ready_o) log_grant(K_SC, tbl_check_addr_o, tbl_check_id_o);
      if (tbl_clr_req_o && tbl_clr_gnt_i && !wr_ready_o) log_grant(K_CLR, tbl_clr_addr_o, '0);
      if (sc_rsp_valid_o && sc_rsp_ready_i) begin
        $display("[%0t] sc_rsp ok=%0d id=%0d", $time, sc_rsp_ok_o, sc_rsp_id_o);
        if (rq.size() == 0) begin
          check_eq("rsp_unexpected", 1, 0);
        end else begin
          r = rq.pop_front();
          check_eq("rsp_ok", {63'd0, sc_rsp_ok_o}, {63'd0, r.ok});
          check_eq("rsp_id", {60'd0, sc_rsp_id_o}, {60'd0, r.id});
        end
      end
    end
  end

  // Stream drivers: raise valid, wait (bounded) for ready, drop after the handshake edge.
  task automatic do_wr(input logic [AW-1:0] a);
    int   n = 0;
    logic got = 1'b0;
    wr_valid_i = 1'b1;
    wr_addr_i  = a;
    while (!got && n < 50) begin
      @(negedge clk_i);
      if (wr_ready_o) got = 1'b1;
      n++;
    end
    check_eq("wr_accept", {63'd0, got}, 1);
    @(posedge clk_i); #1;
    wr_valid_i = 1'b0;
  endtask

  task automatic do_lr(input logic [IW-1:0] id, input logic [AW-1:0] a);
    int   n = 0;
    logic got = 1'b0;
    lr_valid_i = 1'b1;
    lr_addr_i  = a;
    lr_id_i    = id;
    while (!got && n < 50) begin
      @(negedge clk_i);
      if (lr_ready_o) got = 1'b1;
      n++;
    end
    check_eq("lr_accept", {63'd0, got}, 1);
    @(posedge clk_i); #1;
    lr_valid_i = 1'b0;
  endtask

  task automatic do_sc(input logic [IW-1:0] id, input logic [AW-1:0] a);
    int   n = 0;
    logic got = 1'b0;
    sc_valid_i = 1'b1;
    sc_addr_i  = a;
    sc_id_i    = id;
    while (!got && n < 50) begin
      @(negedge clk_i);
      if (sc_ready_o) got = 1'b1;
      n++;
    end
    check_eq("sc_accept", {63'd0, got}, 1);
    @(posedge clk_i); #1;
    sc_valid_i = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (rq.size() != 0 && n < 50) begin
      @(posedge clk_i);
      n++;
    end
    #1;
    check_eq("rsp_drained", rq.size(), 0);
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // T1: reset with every valid high
    rst_ni          = 1'b0;
    wr_valid_i      = 1'b1;
    wr_addr_i       = 64'hA000;
    lr_valid_i      = 1'b1;
    lr_addr_i       = 64'hB000;
    lr_id_i         = 4'd1;
    sc_valid_i      = 1'b1;
    sc_addr_i       = 64'hB000;
    sc_id_i         = 4'd1;
    sc_rsp_ready_i  = 1'b1;
    tbl_clr_gnt_i   = 1'b1;
    tbl_set_gnt_i   = 1'b1;
    tbl_check_gnt_i = 1'b1;
    repeat (2) begin
      @(negedge clk_i);
      check_eq("rst_outputs", {56'd0, wr_ready_o, lr_ready_o, sc_ready_o, tbl_clr_req_o,
                               tbl_set_req_o, tbl_check_req_o, sc_rsp_valid_o, sc_rsp_ok_o}, 0);
      check_eq("rst_rsp_id", {60'd0, sc_rsp_id_o}, 0);
    end
    @(posedge clk_i); #1;
    push_g(K_WR, 64'hA000, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);
    @(posedge clk_i); #1;
    wr_valid_i = 1'b0;
    lr_valid_i = 1'b0;
    sc_valid_i = 1'b0;

    // T2: LR then matching SC passes with an exclusive clear; a repeat SC fails
    push_g(K_LR, 64'h1000, 4'd3);
    do_lr(4'd3, 64'h1000);
    push_g(K_SC, 64'h1000, 4'd3);
    push_g(K_CLR, 64'h1000, '0);
    push_r(1'b1, 4'd3);
    do_sc(4'd3, 64'h1000);
    @(negedge clk_i);
    check_eq("t2_clr_req", {63'd0, tbl_clr_req_o}, 1);
    check_eq("t2_clr_addr", tbl_clr_addr_o, 64'h1000);
    check_eq("t2_rsp_early", {63'd0, sc_rsp_valid_o}, 0);
    @(negedge clk_i);
    check_eq("t2_rsp_valid", {63'd0, sc_rsp_valid_o}, 1);
    wait_rsp();
    push_g(K_SC, 64'h1000, 4'd3);
    push_r(1'b0, 4'd3);
    do_sc(4'd3, 64'h1000);
    @(negedge clk_i);
    check_eq("t2b_rsp_valid", {63'd0, sc_rsp_valid_o}, 1);
    check_eq("t2b_no_clr", {63'd0, tbl_clr_req_o}, 0);
    wait_rsp();

    // T3: intervening write to the address makes the SC fail, no clear follows
    push_g(K_LR, 64'h1000, 4'd3);
    do_lr(4'd3, 64'h1000);
    push_g(K_WR, 64'h1000, '0);
    do_wr(64'h1000);
    push_g(K_SC, 64'h1000, 4'd3);
    push_r(1'b0, 4'd3);
    do_sc(4'd3, 64'h1000);
    @(negedge clk_i);
    check_eq("t3_no_clr", {63'd0, tbl_clr_req_o}, 0);
    check_eq("t3_rsp_valid", {63'd0, sc_rsp_valid_o}, 1);
    wait_rsp();

    // T4: all three streams valid for 28 cycles -> WR, LR, SC, CLR repeating
    do_reset();
    for (int i = 0; i < 7; i++) begin
      push_g(K_WR, 64'hC000, '0);
      push_g(K_LR, 64'h1000, 4'd3);
      push_g(K_SC, 64'h1000, 4'd3);
      push_g(K_CLR, 64'h1000, '0);
      push_r(1'b1, 4'd3);
    end
    wr_valid_i = 1'b1;
    wr_addr_i  = 64'hC000;
    lr_valid_i = 1'b1;
    lr_addr_i  = 64'h1000;
    lr_id_i    = 4'd3;
    sc_valid_i = 1'b1;
    sc_addr_i  = 64'h1000;
    sc_id_i    = 4'd3;
    repeat (28) @(posedge clk_i);
    #1;
    wr_valid_i = 1'b0;
    lr_valid_i = 1'b0;
    sc_valid_i = 1'b0;
    wait_rsp();
    check_eq("t4_grants_left", gq.size(), 0);

    // T5: response back-pressure; WR/LR still served, SC held off
    sc_rsp_ready_i = 1'b0;
    push_g(K_LR, 64'h2000, 4'd5);
    do_lr(4'd5, 64'h2000);
    push_g(K_SC, 64'h2000, 4'd5);
    push_g(K_CLR, 64'h2000, '0);
    push_r(1'b1, 4'd5);
    do_sc(4'd5, 64'h2000);
    @(posedge clk_i); #1;
    push_g(K_WR, 64'h4000, '0);
    push_g(K_LR, 64'h3000, 4'd6);
    sc_valid_i = 1'b1;
    sc_addr_i  = 64'h5000;
    sc_id_i    = 4'd7;
    fork
      do_wr(64'h4000);
      do_lr(4'd6, 64'h3000);
      begin
        for (int i = 0; i < 5; i++) begin
          @(negedge clk_i);
          check_eq("t5_rsp_valid", {63'd0, sc_rsp_valid_o}, 1);
          check_eq("t5_rsp_ok", {63'd0, sc_rsp_ok_o}, 1);
          check_eq("t5_rsp_id", {60'd0, sc_rsp_id_o}, 5);
          check_eq("t5_sc_ready", {63'd0, sc_ready_o}, 0);
        end
      end
    join
    @(posedge clk_i); #1;
    sc_rsp_ready_i = 1'b1;
    push_g(K_SC, 64'h5000, 4'd7);
    push_r(1'b0, 4'd7);
    do_sc(4'd7, 64'h5000);
    wait_rsp();

    // T6: table set port stalls for 3 cycles; LR request held and locked in
    push_g(K_WR, 64'h7000, '0);
    do_wr(64'h7000);
    tbl_set_gnt_i = 1'b0;
    lr_valid_i    = 1'b1;
    lr_addr_i     = 64'h6000;
    lr_id_i       = 4'd2;
    wr_valid_i    = 1'b1;
    wr_addr_i     = 64'h8000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check_eq("t6_set_req", {63'd0, tbl_set_req_o}, 1);
      check_eq("t6_set_addr", tbl_set_addr_o, 64'h6000);
      check_eq("t6_set_id", {60'd0, tbl_set_id_o}, 2);
      check_eq("t6_other_req", {62'd0, tbl_clr_req_o, tbl_check_req_o}, 0);
      check_eq("t6_readies", {62'd0, lr_ready_o, wr_ready_o}, 0);
      @(posedge clk_i); #1;
    end
    tbl_set_gnt_i = 1'b1;
    sc_valid_i    = 1'b1;
    sc_addr_i     = 64'h6000;
    sc_id_i       = 4'd2;
    push_g(K_LR, 64'h6000, 4'd2);
    push_g(K_SC, 64'h6000, 4'd2);
    push_g(K_CLR, 64'h6000, '0);
    push_g(K_WR, 64'h8000, '0);
    push_r(1'b1, 4'd2);
    fork
      do_lr(4'd2, 64'h6000);
      do_wr(64'h8000);
      do_sc(4'd2, 64'h6000);
    join
    wait_rsp();

    // T7: reset during the exclusive clear drops the SC without a response
    push_g(K_LR, 64'h9000, 4'd1);
    do_lr(4'd1, 64'h9000);
    push_g(K_SC, 64'h9000, 4'd1);
    do_sc(4'd1, 64'h9000);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      check_eq("t7_no_rsp", {63'd0, sc_rsp_valid_o}, 0);
    end

    check_eq("grants_left", gq.size(), 0);
    check_eq("rsps_left", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
